// File: rtl/pb_debounce_repeat.sv
// ============================================================================
// pb_debounce_repeat : per-button synchroniser, debouncer, press/release pulses
//                      and auto-repeat for raw board pushbuttons.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pb_debounce_repeat #(
  parameter int N_PBs           = 3,
  parameter int CNT_W           = 26,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [N_PBs-1:0] PB_RAW,
  output logic [N_PBs-1:0] PB_LEVEL,
  output logic [N_PBs-1:0] PB_PULSE,
  output logic [N_PBs-1:0] PB_RELEASE
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam bit               REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST   = CNT_W'(REPEAT_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [N_PBs-1:0] s1_q, s1_d;
  logic [N_PBs-1:0] s2_q, s2_d;

  always_comb begin
    s1_d = PB_RAW;
    s2_d = s1_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  for (genvar i = 0; i < N_PBs; i++) begin : g_ch
    state_t           state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] rcnt_q, rcnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;
    logic             rel_q, rel_d;

    always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      rcnt_d  = rcnt_q;
      level_d = level_q;
      pulse_d = 1'b0;
      rel_d   = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s2_q[i]) begin
            if (dcnt_q == DB_LAST) begin
              state_d = ST_HELD;
              level_d = 1'b1;
              pulse_d = 1'b1;
              dcnt_d  = '0;
              rcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + ONE;
            end
          end else begin
            dcnt_d = '0;
          end
        end
        ST_HELD, ST_REPEAT: begin
          if (state_q == ST_HELD) begin
            if (REPEAT_EN) begin
              if (rcnt_q == RD_LAST) begin
                pulse_d = 1'b1;
                state_d = ST_REPEAT;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_q + ONE;
              end
            end
          end else if (rcnt_q == RP_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + ONE;
          end
          // An accepted release wins over a repeat landing on the same cycle.
          if (!s2_q[i]) begin
            if (dcnt_q == DB_LAST) begin
              state_d = ST_IDLE;
              level_d = 1'b0;
              rel_d   = 1'b1;
              pulse_d = 1'b0;
              dcnt_d  = '0;
              rcnt_d  = '0;
            end else begin
              dcnt_d = dcnt_q + ONE;
            end
          end else begin
            dcnt_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          level_d = 1'b0;
          dcnt_d  = '0;
          rcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        state_q <= ST_IDLE;
        dcnt_q  <= '0;
        rcnt_q  <= '0;
        level_q <= 1'b0;
        pulse_q <= 1'b0;
        rel_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        dcnt_q  <= dcnt_d;
        rcnt_q  <= rcnt_d;
        level_q <= level_d;
        pulse_q <= pulse_d;
        rel_q   <= rel_d;
      end
    end

    assign PB_LEVEL[i]   = level_q;
    assign PB_PULSE[i]   = pulse_q;
    assign PB_RELEASE[i] = rel_q;
  end

endmodule

`default_nettype wire
